// File: rtl/echo_player_if.sv
// echo_player bus bundle: control, BRAM read port and output stream.
// master = the player, slave = its environment.
interface echo_player_if #(
    parameter int ADDR_WIDTH = 16
);
    logic                    play_in;
    logic                    loop_in;
    logic [ADDR_WIDTH-1:0]   length_in;
    logic                    audio_valid_in;
    logic [ADDR_WIDTH-1:0]   ram_addr_out;
    logic signed [7:0]       ram_data_in;
    logic signed [7:0]       sample_out;
    logic                    sample_valid_out;
    logic                    busy_out;
    logic                    done_out;

    modport master (
        input  play_in,
        input  loop_in,
        input  length_in,
        input  audio_valid_in,
        input  ram_data_in,
        output ram_addr_out,
        output sample_out,
        output sample_valid_out,
        output busy_out,
        output done_out
    );

    modport slave (
        output play_in,
        output loop_in,
        output length_in,
        output audio_valid_in,
        output ram_data_in,
        input  ram_addr_out,
        input  sample_out,
        input  sample_valid_out,
        input  busy_out,
        input  done_out
    );
endinterface

// File: rtl/echo_player.sv
// echo_player: streams recorded samples from BRAM, mixing in two
// attenuated delayed echo taps, one output per sample-rate strobe.
module echo_player #(
    parameter int ADDR_WIDTH  = 16,
    parameter int TAP1_DELAY  = 1500,
    parameter int TAP2_DELAY  = 3000,
    parameter int RAM_LATENCY = 2
) (
    input  logic          clk_in,
    input  logic          rst_in,
    echo_player_if.master bus
);
    localparam int CW = $clog2(RAM_LATENCY + 5);
    localparam logic [ADDR_WIDTH-1:0] D1 = ADDR_WIDTH'(TAP1_DELAY);
    localparam logic [ADDR_WIDTH-1:0] D2 = ADDR_WIDTH'(TAP2_DELAY);
    localparam logic [CW-1:0] C_ONE = CW'(1);
    localparam logic [CW-1:0] C_S0  = CW'(RAM_LATENCY + 1);
    localparam logic [CW-1:0] C_S1  = CW'(RAM_LATENCY + 2);
    localparam logic [CW-1:0] C_S2  = CW'(RAM_LATENCY + 3);

    typedef enum logic [2:0] {
        IDLE, WAIT_TICK, ISSUE, COLLECT, MIX
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0] len_q, len_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CW-1:0]         cyc_q, cyc_d;
    logic signed [7:0]     s0_q, s0_d;
    logic signed [7:0]     s1_q, s1_d;
    logic signed [7:0]     s2_q, s2_d;
    logic signed [7:0]     sample_q, sample_d;
    logic                  valid_q, valid_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  play_q, play_d;

    logic                  tap1_on, tap2_on;
    logic [ADDR_WIDTH-1:0] tap1_addr, tap2_addr;
    logic signed [9:0]     e0, e1, e2, sum;
    logic signed [7:0]     sat;
    logic                  last;

    // Tap gating, echo mix with saturation, end-of-buffer test.
    always_comb begin
        tap1_on   = ptr_q >= D1;
        tap2_on   = ptr_q >= D2;
        tap1_addr = tap1_on ? ptr_q - D1 : '0;
        tap2_addr = tap2_on ? ptr_q - D2 : '0;
        e0  = {{2{s0_q[7]}}, s0_q};
        e1  = {{3{s1_q[7]}}, s1_q[7:1]};
        e2  = {{4{s2_q[7]}}, s2_q[7:2]};
        sum = e0 + e1 + e2;
        if (sum > 10'sd127) begin
            sat = 8'sd127;
        end else if (sum < -10'sd128) begin
            sat = -8'sd128;
        end else begin
            sat = sum[7:0];
        end
        last = ({1'b0, ptr_q} + (ADDR_WIDTH + 1)'(1))
               >= {1'b0, len_q};
    end

    // Next-state logic: sequencing, tap capture and pointer advance.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        len_d    = len_q;
        addr_d   = addr_q;
        cyc_d    = cyc_q;
        s0_d     = s0_q;
        s1_d     = s1_q;
        s2_d     = s2_q;
        sample_d = sample_q;
        valid_d  = 1'b0;
        busy_d   = busy_q;
        done_d   = 1'b0;
        play_d   = bus.play_in;

        if (state_q == ISSUE || state_q == COLLECT) begin
            cyc_d = cyc_q + C_ONE;
            if (cyc_q == C_S0) s0_d = bus.ram_data_in;
            if (cyc_q == C_S1) s1_d = tap1_on ? bus.ram_data_in : '0;
            if (cyc_q == C_S2) s2_d = tap2_on ? bus.ram_data_in : '0;
        end

        unique case (state_q)
            IDLE: begin
                if (bus.play_in && !play_q && bus.length_in != '0) begin
                    len_d   = bus.length_in;
                    ptr_d   = '0;
                    busy_d  = 1'b1;
                    state_d = WAIT_TICK;
                end
            end
            WAIT_TICK: begin
                if (!bus.play_in) begin
                    ptr_d   = '0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (bus.audio_valid_in) begin
                    addr_d  = ptr_q;
                    cyc_d   = C_ONE;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (cyc_q == C_ONE) begin
                    addr_d = tap1_addr;
                end else begin
                    addr_d  = tap2_addr;
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (cyc_q == C_S2) state_d = MIX;
            end
            MIX: begin
                sample_d = sat;
                valid_d  = 1'b1;
                if (!bus.play_in) begin
                    ptr_d   = '0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (!last) begin
                    ptr_d   = ptr_q + 1'b1;
                    state_d = WAIT_TICK;
                end else if (bus.loop_in) begin
                    ptr_d   = '0;
                    state_d = WAIT_TICK;
                end else begin
                    ptr_d   = '0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset aborts playback at once.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            len_q    <= '0;
            addr_q   <= '0;
            cyc_q    <= '0;
            s0_q     <= '0;
            s1_q     <= '0;
            s2_q     <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            play_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            len_q    <= len_d;
            addr_q   <= addr_d;
            cyc_q    <= cyc_d;
            s0_q     <= s0_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            play_q   <= play_d;
        end
    end

    assign bus.ram_addr_out     = addr_q;
    assign bus.sample_out       = sample_q;
    assign bus.sample_valid_out = valid_q;
    assign bus.busy_out         = busy_q;
    assign bus.done_out         = done_q;
endmodule
